reg_dump: RTL

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump.sv | 139 +++++++++++++
 1 files changed

// File: rtl/reg_dump.sv
// ----------------------------------------------------------------------------
// reg_dump
// Walks register-file indices FIRST_REG..LAST_REG on request and streams each
// value out as a valid/ready beat tagged with its index. Each beat costs one
// READ cycle (capture from the combinational read port) and at least one SEND
// cycle (wait for the sink), so throughput is at most one beat per two cycles.
//
// Ports
//   clk        in   1   clock, all state changes on the rising edge
//   rst_n      in   1   synchronous active-low reset
//   start      in   1   dump request, only looked at while idle
//   abort      in   1   cancel the dump in progress
//   rf_addr    out  5   register-file read address (current index)
//   rf_data    in  32   register-file read data for rf_addr, same cycle
//   out_valid  out  1   stream beat valid
//   out_ready  in   1   stream sink ready
//   out_data   out 32   captured register value
//   out_idx    out  5   register index of out_data
//   out_last   out  1   beat carries LAST_REG
//   busy       out  1   high whenever a dump is in progress (not idle)
//   done       out  1   one-cycle pulse when a dump completes
// ----------------------------------------------------------------------------
module reg_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [4:0]  r_idx;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic [4:0]  r_out_idx;
    logic        r_out_last;
    logic        r_busy;
    logic        r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= FIRST_IDX;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_idx   <= 5'd0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // done is a pulse: only the SEND->DONE transition raises it
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort beats a simultaneous start
                    if (start && !abort) begin
                        r_state <= S_READ;
                        r_idx   <= FIRST_IDX;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_idx       <= FIRST_IDX;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_out_data  <= rf_data;
                        r_out_idx   <= r_idx;
                        r_out_last  <= (r_idx == LAST_IDX);
                        r_out_valid <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    // abort discards a coinciding handshake: no done, no advance
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_idx       <= FIRST_IDX;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            // out_last guards this: idx never passes LAST_REG
                            r_idx   <= r_idx + 5'd1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_idx   <= FIRST_IDX;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_idx       <= FIRST_IDX;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign rf_addr   = r_idx;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
